// File: rtl/codificador_botones.sv
// -----------------------------------------------------------------------------
// codificador_botones
// Producer side of the direction-command path. Each of the five raw push-buttons
// is synchronised (two flops) and debounced. A rising edge of a debounced level
// is a press event. The highest-priority press of the cycle is encoded and
// queued in a small FIFO that the snake state machine pops once per movement
// tick.
//
// Codes: 0 none, 1 up, 2 down, 3 left, 4 right, 5 pause.
// Priority when several presses land together: pausa > arriba > abajo >
// izquierda > derecha.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   arriba     raw up button
//   abajo      raw down button
//   izquierda  raw left button
//   derecha    raw right button
//   pausa      raw pause button
//   rd_en      pop strobe, one pop per high cycle
//   cmd        FIFO head code, 0 when empty
//   cmd_valid  FIFO not empty
//   count      number of queued codes
//   overflow   one-cycle pulse when a press is dropped on a full FIFO
// -----------------------------------------------------------------------------
module codificador_botones #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int DEPTH           = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arriba,
  input  logic                     abajo,
  input  logic                     izquierda,
  input  logic                     derecha,
  input  logic                     pausa,
  input  logic                     rd_en,
  output logic [2:0]               cmd,
  output logic                     cmd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int NB    = 5;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  // Button bit positions
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_PAUSE = 4;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1_q;
  logic [NB-1:0]    sync2_q;
  logic [NB-1:0]    level_q;
  logic [NB-1:0]    level_d;
  logic [NB-1:0]    prev_q;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];

  logic             push_req;
  logic [2:0]       push_code;

  logic [2:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign raw = {pausa, derecha, izquierda, abajo, arriba};

  // Debounce: the counter only runs while the synced level disagrees with the
  // accepted level, so any disagreement shorter than DEBOUNCE_CYCLES is lost.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Only rising edges are events; releases are debounced but silent.
  assign press = level_q & ~prev_q;

  always_comb begin
    push_req  = |press;
    push_code = 3'd0;
    if (press[B_PAUSE])      push_code = 3'd5;
    else if (press[B_UP])    push_code = 3'd1;
    else if (press[B_DOWN])  push_code = 3'd2;
    else if (press[B_LEFT])  push_code = 3'd3;
    else if (press[B_RIGHT]) push_code = 3'd4;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop on an empty FIFO is ignored (no bypass), and a pop frees a slot for a
  // simultaneous push even when full.
  assign do_pop   = rd_en & ~empty;
  assign do_push  = push_req & (~full | do_pop);
  assign overflow = push_req & full & ~do_pop;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      prev_q   <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_code;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign cmd       = empty ? 3'd0 : mem_q[rd_ptr_q];
  assign cmd_valid = ~empty;
  assign count     = count_q;

endmodule

// File: tb/tb_codificador_botones.sv
module tb_codificador_botones;

  logic       clk = 1'b0;
  logic       rst;
  logic       arriba, abajo, izquierda, derecha, pausa, rd_en;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [2:0] count;
  logic       overflow;

  int n_vec = 0;
  int n_bad = 0;

  codificador_botones #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arriba(arriba),
    .abajo(abajo),
    .izquierda(izquierda),
    .derecha(derecha),
    .pausa(pausa),
    .rd_en(rd_en),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one button by code (1 up, 2 down, 3 left, 4 right, 5 pause).
  task automatic set_btn(input int code, input logic v);
    case (code)
      1: arriba    = v;
      2: abajo     = v;
      3: izquierda = v;
      4: derecha   = v;
      5: pausa     = v;
      default: ;
    endcase
  endtask

  // Full press: hold long enough to push, release long enough to settle.
  task automatic press(input int code);
    set_btn(code, 1'b1);
    tick(8);
    set_btn(code, 1'b0);
    tick(8);
  endtask

  task automatic pop_expect(input string tag, input int code);
    chk(tag, {29'd0, cmd}, code);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    arriba = 0; abajo = 0; izquierda = 0; derecha = 0; pausa = 0; rd_en = 0;
    tick(3);
    chk("rst_cmd", {29'd0, cmd}, 0);
    chk("rst_valid", {31'd0, cmd_valid}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    rst = 1'b0;

    // 1. Latency: valid appears exactly 7 edges after the press
    arriba = 1'b1;
    tick(6);
    chk("lat_e6_valid", {31'd0, cmd_valid}, 0);
    tick(1);
    chk("lat_e7_valid", {31'd0, cmd_valid}, 1);
    chk("lat_cmd", {29'd0, cmd}, 1);
    chk("lat_count", {29'd0, count}, 1);
    tick(10);
    chk("hold_count", {29'd0, count}, 1);
    arriba = 1'b0;
    tick(10);
    chk("release_count", {29'd0, count}, 1);
    pop_expect("t1_pop", 1);
    chk("t1_empty", {29'd0, count}, 0);

    // 2. Short pulse and bounce must be filtered
    derecha = 1'b1; tick(3); derecha = 1'b0; tick(1);
    derecha = 1'b1; tick(1); derecha = 1'b0; tick(1);
    derecha = 1'b1; tick(1); derecha = 1'b0;
    tick(12);
    chk("glitch_count", {29'd0, count}, 0);
    chk("glitch_valid", {31'd0, cmd_valid}, 0);

    // 3. Simultaneous pause and left: pause wins, left lost
    pausa = 1'b1; izquierda = 1'b1;
    tick(7);
    chk("prio_count", {29'd0, count}, 1);
    chk("prio_cmd", {29'd0, cmd}, 5);
    tick(6);
    chk("prio_single", {29'd0, count}, 1);
    pausa = 1'b0; izquierda = 1'b0;
    tick(8);
    pop_expect("prio_pop", 5);
    chk("prio_after", {29'd0, count}, 0);

    // 4. Fill, overflow, drain in order
    press(1); press(2); press(3); press(4);
    chk("full_count", {29'd0, count}, 4);
    arriba = 1'b1;
    tick(5);
    chk("ovf_pre", {31'd0, overflow}, 0);
    tick(1);
    chk("ovf_pulse", {31'd0, overflow}, 1);
    tick(1);
    chk("ovf_post", {31'd0, overflow}, 0);
    chk("ovf_count", {29'd0, count}, 4);
    chk("ovf_head", {29'd0, cmd}, 1);
    arriba = 1'b0;
    tick(8);
    pop_expect("drain0", 1);
    pop_expect("drain1", 2);
    pop_expect("drain2", 3);
    pop_expect("drain3", 4);
    chk("drain_cmd", {29'd0, cmd}, 0);
    chk("drain_valid", {31'd0, cmd_valid}, 0);
    chk("drain_count", {29'd0, count}, 0);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    chk("underflow_count", {29'd0, count}, 0);

    // Push + pop together while empty: push stored, pop ignored
    abajo = 1'b1;
    tick(6);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("emptypp_count", {29'd0, count}, 1);
    chk("emptypp_cmd", {29'd0, cmd}, 2);
    abajo = 1'b0;
    tick(8);
    pop_expect("emptypp_pop", 2);

    // 5. Full FIFO, press coincides with pop
    press(1); press(2); press(3); press(4);
    pausa = 1'b1;
    tick(6);
    rd_en = 1'b1;
    #1;
    chk("fullpp_ovf", {31'd0, overflow}, 0);
    tick(1);
    rd_en = 1'b0;
    chk("fullpp_count", {29'd0, count}, 4);
    chk("fullpp_head", {29'd0, cmd}, 2);
    pausa = 1'b0;
    tick(8);
    pop_expect("fullpp0", 2);
    pop_expect("fullpp1", 3);
    pop_expect("fullpp2", 4);
    pop_expect("fullpp3", 5);
    chk("fullpp_empty", {29'd0, count}, 0);

    // 6. Asynchronous reset mid-operation
    press(1); press(2);
    chk("pre_rst_count", {29'd0, count}, 2);
    izquierda = 1'b1;
    tick(2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_count", {29'd0, count}, 0);
    chk("arst_cmd", {29'd0, cmd}, 0);
    chk("arst_valid", {31'd0, cmd_valid}, 0);
    tick(3);
    rst = 1'b0;
    tick(6);
    chk("post_rst_e6", {29'd0, count}, 0);
    tick(1);
    chk("post_rst_e7", {29'd0, count}, 1);
    chk("post_rst_cmd", {29'd0, cmd}, 3);
    tick(10);
    chk("post_rst_hold", {29'd0, count}, 1);
    izquierda = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
